uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_FREQ, default 12_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, line bit rate in baud.
REQ-003 clock  input  1  single system clock; all logic on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  asynchronous serial line; idle high.
REQ-006 write_data  output  8  last received byte; LSB received first.
REQ-007 write_clock_enable  output  1  one-cycle strobe; write_data valid in the same cycle.
REQ-008 framing_error  output  1  one-cycle strobe; stop bit sampled low.
REQ-009 parity_error  output  1  one-cycle strobe; parity mismatch; constant 0 without the macro.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 The block SHALL pass rx through a 2-flop synchronizer reset to 1; all logic below uses the synchronized rx_s only.
REQ-012 CLOCKS_PER_BIT SHALL be CLOCK_FREQ/BAUD_RATE, truncated (104 at defaults); HALF_BIT SHALL be CLOCKS_PER_BIT/2.
REQ-013 The bit counter SHALL be 8 bits; elaboration SHALL fail if CLOCKS_PER_BIT < 4 or > 255.
REQ-014 States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
REQ-015 IDLE->START when rx_s goes 1->0 (previous rx_s 1, current 0); counter cleared.
REQ-016 START: when counter = HALF_BIT-1, the block samples rx_s; 1 is a glitch and goes to IDLE with no strobe; 0 goes to DATA with counter and bit index cleared.
REQ-017 DATA: when counter = CLOCKS_PER_BIT-1, rx_s is shifted into bit[index]; after index 7 the state goes to PARITY (macro) or STOP.
REQ-018 STOP: when counter = CLOCKS_PER_BIT-1 and rx_s = 1, the byte is written to write_data, write_clock_enable pulses for exactly one cycle, and the state goes to IDLE.
REQ-019 STOP with rx_s = 0 SHALL pulse framing_error, SHALL NOT update write_data or strobe write_clock_enable, and SHALL go to WAIT_HIGH.
REQ-020 WAIT_HIGH->IDLE on the first cycle rx_s = 1; a line held low (break) SHALL produce no further strobes.
REQ-021 write_data SHALL hold its value until the next good frame; no consumer handshake; a new byte overwrites unconditionally.
REQ-022 The first data bit SHALL be sampled CLOCKS_PER_BIT+HALF_BIT cycles after the detected falling edge of rx_s; each later bit is sampled CLOCKS_PER_BIT cycles after the previous one.
REQ-023 A falling edge during STOP or WAIT_HIGH SHALL NOT start a frame; back-to-back frames SHALL be accepted because STOP returns to IDLE mid-bit.

Reset
REQ-024 Reset SHALL be asynchronous: while reset = 0, state = IDLE, counter = 0, synchronizer = 1, write_data = 0, and all strobes and busy = 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte; after release, a frame is detected only on a fresh 1->0 edge.

Configuration
REQ-026 With macro UART_RX_PARITY_EN defined, one parity bit SHALL follow bit 7; it is sampled in PARITY at counter = CLOCKS_PER_BIT-1.
REQ-027 Parity is odd: expected bit = ~^data. On mismatch, parity_error pulses and the byte is still delivered together with write_clock_enable.
REQ-028 Without UART_RX_PARITY_EN, the PARITY state and its logic SHALL be absent, frames are 8N1, and parity_error is tied to 0.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum, the parity function, and the CLOCKS_PER_BIT/HALF_BIT calculation, shared with the transmitter.
REQ-030 The synchronizer SHALL be sub-module uart_sync (2 flops, reset value 1); all other logic lives in uart_rx.

Verification
REQ-031 Defaults, 8N1, send 0xA5 at exactly 115200 baud -> write_data = 0xA5, one write_clock_enable pulse, no error strobes.
REQ-032 Low glitch on rx lasting 30 clocks -> no strobe; busy returns to 0 within 54 cycles.
REQ-033 Stop bit forced low on byte 0x3C -> framing_error pulses once; write_data keeps its prior value; no further strobes while rx stays low for 2000 clocks.
REQ-034 Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three strobes in order with correct data.
REQ-035 Reset pulsed during bit 4 of 0x81 -> no strobe; the next frame 0x7E is received correctly.
REQ-036 UART_RX_PARITY_EN: 0x07 with parity bit 0 -> no error; with parity bit 1 -> parity_error and write_clock_enable in the same cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-timing math and parity helper.
// Used by the receiver and the matching transmitter.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_e;
`endif

  function automatic int clocks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: received byte, its strobe, error strobes and busy.
interface uart_rx_if;
  logic [7:0] write_data;
  logic       write_clock_enable;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  modport master (
    output write_data,
    output write_clock_enable,
    output framing_error,
    output parity_error,
    output busy
  );

  modport slave (
    input write_data,
    input write_clock_enable,
    input framing_error,
    input parity_error,
    input busy
  );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, one stop bit, mid-bit sampling.
// Define UART_RX_PARITY_EN to add one odd parity bit after bit 7 (8O1).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 12_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  uart_rx_if.master  rx_if
);

  localparam int         CPB       = clocks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int         HALF      = half_bit(CPB);
  localparam logic [7:0] BIT_LAST  = 8'(CPB - 1);
  localparam logic [7:0] HALF_LAST = 8'(HALF - 1);

  generate
    if (CPB < 4 || CPB > 255) begin : g_bad_cpb
      $error("uart_rx: CLOCKS_PER_BIT must be within 4..255");
    end
  endgenerate

  logic        rx_s;
  logic        rx_prev;
  logic [1:0]  settle;
  logic        armed;
  uart_state_e state;
  logic [7:0]  cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [7:0]  write_data_q;
  logic        wce_q;
  logic        fe_q;
`ifdef UART_RX_PARITY_EN
  logic        par_bad;
  logic        pe_q;
`endif

  uart_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // The synchronizer comes out of reset reading 1 regardless of the line, so a
  // line that is low at release would look like a start edge. Edge detection is
  // armed only once the real line has been seen high after the flops have flushed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_prev      <= 1'b1;
      settle       <= 2'd0;
      armed        <= 1'b0;
      state        <= IDLE;
      cnt          <= 8'd0;
      bit_idx      <= 3'd0;
      shift        <= 8'd0;
      write_data_q <= 8'd0;
      wce_q        <= 1'b0;
      fe_q         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      pe_q         <= 1'b0;
`endif
    end else begin
      wce_q   <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q    <= 1'b0;
`endif
      rx_prev <= rx_s;
      if (settle != 2'd2) settle <= settle + 2'd1;
      else if (rx_s)      armed  <= 1'b1;

      case (state)
        IDLE: begin
          if (armed && rx_prev && !rx_s) begin
            state <= START;
            cnt   <= 8'd0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= 8'd0;
            bit_idx <= 3'd0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= 8'd0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= 8'd0;
            par_bad <= (rx_s != odd_parity(shift));
            state   <= STOP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
`endif
        // Leaving STOP at mid-bit lets a back-to-back start edge be caught.
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= 8'd0;
            if (rx_s) begin
              write_data_q <= shift;
              wce_q        <= 1'b1;
`ifdef UART_RX_PARITY_EN
              pe_q         <= par_bad;
`endif
              state        <= IDLE;
            end else begin
              fe_q  <= 1'b1;
              state <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_if.write_data         = write_data_q;
  assign rx_if.write_clock_enable = wce_q;
  assign rx_if.framing_error      = fe_q;
  assign rx_if.busy               = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_error       = pe_q;
`else
  assign rx_if.parity_error       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default timing (104 clocks per bit).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 104;

  logic clock;
  logic reset;
  logic rx;

  int tests_run;
  int tests_failed;
  int wce_cnt;
  int fe_cnt;
  int pe_cnt;
  int pe_with_wce;
  logic [7:0] data_q[$];

  uart_rx_if rx_if ();

  uart_rx #(
    .CLOCK_FREQ (12_000_000),
    .BAUD_RATE  (115_200)
  ) dut (
    .clock (clock),
    .reset (reset),
    .rx    (rx),
    .rx_if (rx_if.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_if.write_clock_enable === 1'b1) begin
      wce_cnt++;
      data_q.push_back(rx_if.write_data);
      if (rx_if.parity_error === 1'b1) pe_with_wce++;
    end
    if (rx_if.framing_error === 1'b1) fe_cnt++;
    if (rx_if.parity_error === 1'b1)  pe_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame bits in line order: start, 8 data LSB first, [parity], stop.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    logic [10:0] f;
    int nb;
    f  = {stop, par, b, 1'b0};
    nb = 11;
`ifndef UART_RX_PARITY_EN
    f[9] = stop;
    nb   = 10;
`endif
    for (int i = 0; i < nb; i++) begin
      rx = f[i];
      tick(CPB);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1);
  endtask

  function automatic logic [7:0] pop_data();
    if (data_q.size() == 0) return 8'hxx;
    return data_q.pop_front();
  endfunction

  initial begin
    int w0;
    int f0;
    logic [7:0] b81;
    tests_run    = 0;
    tests_failed = 0;
    wce_cnt      = 0;
    fe_cnt       = 0;
    pe_cnt       = 0;
    pe_with_wce  = 0;
    rx           = 1'b1;
    reset        = 1'b0;

    tick(3);
    check("reset_write_data", 32'(rx_if.write_data), 32'h00);
    check("reset_wce",        32'(rx_if.write_clock_enable), 32'h0);
    check("reset_fe",         32'(rx_if.framing_error), 32'h0);
    check("reset_pe",         32'(rx_if.parity_error), 32'h0);
    check("reset_busy",       32'(rx_if.busy), 32'h0);
    reset = 1'b1;
    tick(20);

    // Single byte 0xA5
    send_byte(8'hA5);
    tick(20);
    check("a5_wce_count", 32'(wce_cnt), 32'd1);
    check("a5_data",      32'(pop_data()), 32'hA5);
    check("a5_write_data", 32'(rx_if.write_data), 32'hA5);
    check("a5_fe_count",  32'(fe_cnt), 32'd0);
    check("a5_pe_count",  32'(pe_cnt), 32'd0);
    check("a5_idle",      32'(rx_if.busy), 32'h0);

    // 30-clock low glitch
    rx = 1'b0;
    tick(10);
    check("glitch_busy_high", 32'(rx_if.busy), 32'h1);
    tick(20);
    rx = 1'b1;
    tick(28);
    check("glitch_busy_low", 32'(rx_if.busy), 32'h0);
    tick(200);
    check("glitch_no_strobe", 32'(wce_cnt), 32'd1);

    // Stop bit low, then line held low (break)
    send_frame(8'h3C, ~^8'h3C, 1'b0);
    rx = 1'b0;
    tick(2000);
    check("frame_fe_once",      32'(fe_cnt), 32'd1);
    check("frame_no_wce",       32'(wce_cnt), 32'd1);
    check("frame_data_kept",    32'(rx_if.write_data), 32'hA5);
    check("frame_busy_in_break", 32'(rx_if.busy), 32'h1);
    rx = 1'b1;
    tick(300);
    check("frame_busy_after", 32'(rx_if.busy), 32'h0);
    check("frame_fe_total",   32'(fe_cnt), 32'd1);

    // Back-to-back frames with no idle gap
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h55);
    tick(50);
    check("b2b_wce_count", 32'(wce_cnt), 32'd4);
    check("b2b_first",     32'(pop_data()), 32'h00);
    check("b2b_second",    32'(pop_data()), 32'hFF);
    check("b2b_third",     32'(pop_data()), 32'h55);

    // Reset in the middle of bit 4 of 0x81
    w0  = wce_cnt;
    f0  = fe_cnt;
    b81 = 8'h81;
    rx  = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b81[i];
      tick(CPB);
    end
    rx = b81[4];
    tick(50);
    reset = 1'b0;
    tick(10);
    check("midreset_busy",       32'(rx_if.busy), 32'h0);
    check("midreset_write_data", 32'(rx_if.write_data), 32'h00);
    reset = 1'b1;
    tick(CPB - 60);
    for (int i = 5; i < 8; i++) begin
      rx = b81[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = ~^b81;
    tick(CPB);
`endif
    rx = 1'b1;
    tick(300);
    check("midreset_no_wce", 32'(wce_cnt), 32'(w0));
    check("midreset_no_fe",  32'(fe_cnt), 32'(f0));
    send_byte(8'h7E);
    tick(20);
    check("after_reset_wce",  32'(wce_cnt), 32'(w0 + 1));
    check("after_reset_data", 32'(pop_data()), 32'h7E);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    tick(20);
    check("par_good_data", 32'(pop_data()), 32'h07);
    check("par_good_pe",   32'(pe_cnt), 32'd0);
    send_frame(8'h07, 1'b1, 1'b1);
    tick(20);
    check("par_bad_data",     32'(pop_data()), 32'h07);
    check("par_bad_pe",       32'(pe_cnt), 32'd1);
    check("par_bad_with_wce", 32'(pe_with_wce), 32'd1);
`else
    check("nopar_pe_never", 32'(pe_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
